// File: rtl/dispatcher_pkg.sv
// rtl/dispatcher_pkg.sv - shared defaults and types for the packet dispatcher
package dispatcher_pkg;

    localparam int PACKET_SIZE_DEFAULT = 8;
    localparam int NB_OUTPUTS_DEFAULT  = 4;
    localparam int ID_WIDTH_DEFAULT    = $clog2(NB_OUTPUTS_DEFAULT);

    typedef logic [PACKET_SIZE_DEFAULT-1:0] packet_t;
    typedef logic [ID_WIDTH_DEFAULT-1:0]    id_t;

endpackage

// File: rtl/dispatcher_slot.sv
// rtl/dispatcher_slot.sv - one output slot: registered packet and strobe, zeroed when not selected
module dispatcher_slot
    import dispatcher_pkg::*;
#(
    parameter int PACKET_SIZE = PACKET_SIZE_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [PACKET_SIZE-1:0] packet,
    input  logic                   match,
    output logic [PACKET_SIZE-1:0] packet_q,
    output logic                   strobe
);

    always_ff @(posedge clock) begin
        if (reset) begin
            packet_q <= '0;
            strobe   <= 1'b0;
        end else begin
            strobe   <= match;
            packet_q <= match ? packet : '0;
        end
    end

endmodule

// File: rtl/packet_dispatcher.sv
// rtl/packet_dispatcher.sv - routes one packet per cycle to the slot selected by id
module packet_dispatcher
    import dispatcher_pkg::*;
#(
    parameter  int NB_OUTPUTS  = NB_OUTPUTS_DEFAULT,
    parameter  int PACKET_SIZE = PACKET_SIZE_DEFAULT,
    localparam int ID_WIDTH    = $clog2(NB_OUTPUTS)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [PACKET_SIZE-1:0]            packetIn,
    input  logic                              valid,
    input  logic [ID_WIDTH-1:0]               id,
    output logic [NB_OUTPUTS*PACKET_SIZE-1:0] packetsOut,
    output logic [NB_OUTPUTS-1:0]             produced
);

    logic [NB_OUTPUTS-1:0] match;

    // An id beyond NB_OUTPUTS-1 matches no slot, so the packet is silently dropped.
    for (genvar i = 0; i < NB_OUTPUTS; i++) begin : g_slot
        assign match[i] = valid && (id == ID_WIDTH'(i));

        dispatcher_slot #(
            .PACKET_SIZE (PACKET_SIZE)
        ) u_slot (
            .clock    (clock),
            .reset    (reset),
            .packet   (packetIn),
            .match    (match[i]),
            .packet_q (packetsOut[i*PACKET_SIZE +: PACKET_SIZE]),
            .strobe   (produced[i])
        );
    end

endmodule

// File: tb/tb_packet_dispatcher.sv
// tb/tb_packet_dispatcher.sv - directed scoreboard bench for packet_dispatcher
module tb_packet_dispatcher;
    import dispatcher_pkg::*;

    localparam int NB = 4;
    localparam int PS = 8;

    typedef struct {
        logic [NB*PS-1:0] data;
        logic [NB-1:0]    prod;
        string            tag;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset;
    packet_t         packetIn;
    logic            valid;
    id_t             id;
    logic [NB*PS-1:0] packetsOut;
    logic [NB-1:0]   produced;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    packet_dispatcher #(
        .NB_OUTPUTS  (NB),
        .PACKET_SIZE (PS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .packetIn   (packetIn),
        .valid      (valid),
        .id         (id),
        .packetsOut (packetsOut),
        .produced   (produced)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1);
    end

    task automatic step(input logic r, input logic v, input int idv,
                        input logic [PS-1:0] pkt, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clock);
        reset    = r;
        valid    = v;
        id       = id_t'(idv);
        packetIn = pkt;
        e.data = '0;
        e.prod = '0;
        e.tag  = tag;
        if (!r && v && idv < NB) begin
            e.prod[idv]          = 1'b1;
            e.data[idv*PS +: PS] = pkt;
        end
        sb.push_back(e);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        compared++;
        assert (packetsOut === got.data) else begin
            mismatched++;
            $error("FAIL %s data: observed %h expected %h", got.tag, packetsOut, got.data);
        end
        compared++;
        assert (produced === got.prod) else begin
            mismatched++;
            $error("FAIL %s produced: observed %b expected %b", got.tag, produced, got.prod);
        end
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; id = '0; packetIn = '0;
        step(1'b1, 1'b1, 0, 8'd42, "reset_hold");
        step(1'b0, 1'b0, 0, 8'd42, "reset_release");

        for (int i = 0; i < NB; i++) step(1'b0, 1'b1, i, 8'h2A, $sformatf("walk_id%0d", i));
        step(1'b0, 1'b0, 3, 8'h2A, "deassert");

        step(1'b0, 1'b1, 2, 8'h11, "b2b_first");
        step(1'b0, 1'b1, 2, 8'h22, "b2b_second");

        step(1'b1, 1'b1, 1, 8'hFF, "reset_midstream");
        step(1'b0, 1'b1, 1, 8'hFF, "after_reset");

        step(1'b0, 1'b1, 3, 8'h00, "boundary_00");
        step(1'b0, 1'b1, 3, 8'hFF, "boundary_ff");

        for (int k = 0; k < 16; k++)
            step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, NB-1)),
                 8'($urandom), $sformatf("random%0d", k));

        step(1'b0, 1'b0, 0, 8'h5A, "idle_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
